// File: rtl/i2c_slave_regfile.sv
// I2C slave with a NUM_REGS x 8 register file shared with a host port; SCL/SDA are oversampled,
// synchronised and glitch-filtered on clk. START/STOP override every state; sda_oe moves only on SCL falls.
module i2c_slave_regfile #(
  parameter int NUM_REGS   = 16,
  parameter int FILTER_LEN = 3,
  localparam int PW        = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [6:0]    slave_addr,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic          host_we,
  input  logic [PW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          wr_valid,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t state, state_nxt;

  // Index 1 carries SCL, index 0 carries SDA.
  logic [1:0] sync1, sync2, filt, filt_d;
  logic [3:0] cnt [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_d <= 2'b11;
      cnt[0] <= '0;
      cnt[1] <= '0;
    end else begin
      sync1  <= {scl_i, sda_i};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == 4'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det, sda_f;
  assign sda_f     = filt[0];
  assign scl_rise  = filt[1] & ~filt_d[1];
  assign scl_fall  = ~filt[1] & filt_d[1];
  assign start_det = filt[1] & filt_d[1] & filt_d[0] & ~filt[0];
  assign stop_det  = filt[1] & filt_d[1] & ~filt_d[0] & filt[0];

  logic [7:0]    regs [NUM_REGS];
  logic [7:0]    shift, byte_in;
  logic [2:0]    bit_cnt;
  logic [PW-1:0] ptr;
  logic          rw, ack_phase;
  logic          last_bit, addr_match, is_ack, i2c_we, rd_load;

  assign byte_in    = {shift[6:0], sda_f};
  assign last_bit   = (bit_cnt == 3'd7);
  assign addr_match = (byte_in[7:1] == slave_addr) && (byte_in[7:1] != 7'd0);
  assign is_ack     = state inside {ADDR_ACK, REG_ACK, WDATA_ACK, RDATA_ACK};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ACK states span two SCL falls: the first drives/releases, the second (after ack_phase) exits.
  always_comb begin
    state_nxt = state;
    i2c_we    = 1'b0;
    rd_load   = 1'b0;
    if (start_det) begin
      state_nxt = ADDR;
    end else if (stop_det) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        ADDR:      if (scl_rise && last_bit) state_nxt = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK:  if (scl_fall && ack_phase) begin
                     state_nxt = rw ? RDATA : REG;
                     rd_load   = rw;
                   end
        REG:       if (scl_rise && last_bit) state_nxt = REG_ACK;
        REG_ACK:   if (scl_fall && ack_phase) state_nxt = WDATA;
        WDATA:     if (scl_rise && last_bit) begin
                     state_nxt = WDATA_ACK;
                     i2c_we    = 1'b1;
                   end
        WDATA_ACK: if (scl_fall && ack_phase) state_nxt = WDATA;
        RDATA:     if (scl_rise && last_bit) state_nxt = RDATA_ACK;
        RDATA_ACK: if (scl_rise && sda_f) begin
                     state_nxt = IGNORE;
                   end else if (scl_fall && ack_phase) begin
                     state_nxt = RDATA;
                     rd_load   = 1'b1;
                   end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      ack_phase <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      wr_valid <= i2c_we;
      if (start_det || stop_det) begin
        bit_cnt   <= '0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        if (stop_det) busy <= 1'b0;
      end else begin
        if (state_nxt != state)      ack_phase <= 1'b0;
        else if (is_ack && scl_rise) ack_phase <= 1'b1;
        if (scl_rise && (state inside {ADDR, REG, WDATA, RDATA})) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (state != RDATA) shift <= byte_in;
        end
        if (state == ADDR && scl_rise && last_bit) begin
          rw <= byte_in[0];
          if (addr_match) busy <= 1'b1;
        end
        if (state == REG && scl_rise && last_bit) ptr <= byte_in[PW-1:0];
        if (i2c_we) begin
          ptr     <= ptr + PW'(1);
          wr_addr <= ptr;
          wr_data <= byte_in;
        end
        // The outgoing byte is a private copy, so host writes cannot disturb it mid-shift.
        if (rd_load) begin
          shift  <= regs[ptr];
          sda_oe <= ~regs[ptr][7];
          ptr    <= ptr + PW'(1);
        end else if (scl_fall) begin
          case (state)
            ADDR_ACK, REG_ACK, WDATA_ACK: sda_oe <= ~ack_phase;
            RDATA: begin
              sda_oe <= ~shift[6];
              shift  <= {shift[6:0], 1'b0};
            end
            default: sda_oe <= 1'b0;
          endcase
        end
      end
    end
  end

  // Same-index collision: the bus write takes the slot, the host write is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      host_rdata <= 8'h00;
    end else begin
      if (i2c_we) regs[ptr] <= byte_in;
      if (host_we && !(i2c_we && host_addr == ptr)) regs[host_addr] <= host_wdata;
      host_rdata <= regs[host_addr];
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-banged I2C master on a wired-AND SDA, host-port vector table,
// scoreboards for wr_valid events and bytes read back over the bus.
module tb_i2c_slave_regfile;
  localparam int NUM_REGS   = 16;
  localparam int FILTER_LEN = 3;
  localparam int PW         = 4;
  localparam int Q          = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          scl_m = 1'b1, sda_m = 1'b1, glitch = 1'b0;
  logic [6:0]    slave_addr = 7'h28;
  logic          host_we = 1'b0;
  logic [PW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = 8'h00;
  logic          sda_oe, wr_valid, busy;
  logic [7:0]    host_rdata, wr_data;
  logic [PW-1:0] wr_addr;
  logic          scl_pad, sda_pad;

  assign scl_pad = scl_m ^ glitch;
  assign sda_pad = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.NUM_REGS(NUM_REGS), .FILTER_LEN(FILTER_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .slave_addr(slave_addr), .scl_i(scl_pad), .sda_i(sda_pad),
    .sda_oe(sda_oe), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy)
  );

  int vectors = 0, miscompares = 0;
  int wv_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic wv_d = 1'b0;
  logic [PW+7:0] exp_wr[$];
  logic [7:0]    exp_rd[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_valid) begin
      wv_cnt++;
      check("wr_valid_single_cycle", {31'b0, wv_d}, 0);
      check("wr_valid_expected", {31'b0, exp_wr.size() != 0}, 1);
      if (exp_wr.size() != 0) check("wr_addr_data", {wr_addr, wr_data}, exp_wr.pop_front());
    end
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
    wv_d = wr_valid;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, input logic g, output logic rb);
    wait_q();
    sda_m = b;
    if (g) begin
      repeat (3) @(negedge clk);
      glitch = 1'b1;
      @(negedge clk);
      glitch = 1'b0;
      repeat (Q - 4) @(negedge clk);
    end else begin
      wait_q();
    end
    scl_m = 1'b1;
    wait_q();
    rb = sda_pad;
    wait_q();
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wait_q(); sda_m = 1'b1;
    wait_q(); scl_m = 1'b1;
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_q(); sda_m = 1'b0;
    wait_q(); scl_m = 1'b1;
    wait_q(); sda_m = 1'b1;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, input int gbit, output logic ack);
    logic rb;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], i == gbit, rb);
    bit_xfer(1'b1, 1'b0, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, rb);
      d[i] = rb;
    end
    bit_xfer(nack, 1'b0, rb);
  endtask

  task automatic host_write(input logic [PW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [PW-1:0] a, output logic [7:0] d);
    @(negedge clk);
    host_addr = a;
    @(negedge clk);
    d = host_rdata;
  endtask

  task automatic read_check(input string name, input logic nack);
    logic [7:0] d;
    read_byte(nack, d);
    check(name, d, exp_rd.pop_front());
  endtask

  typedef struct {
    logic          we;
    logic [PW-1:0] addr;
    logic [7:0]    wdata;
    logic [7:0]    exp;
  } hvec_t;

  hvec_t tbl[6];

  initial begin
    logic       ack, got;
    logic [7:0] d;

    tbl[0] = '{1'b1, 4'd1,  8'h12, 8'h12};
    tbl[1] = '{1'b1, 4'd2,  8'h34, 8'h34};
    tbl[2] = '{1'b0, 4'd1,  8'h00, 8'h12};
    tbl[3] = '{1'b0, 4'd0,  8'h00, 8'h00};
    tbl[4] = '{1'b1, 4'd15, 8'hFF, 8'hFF};
    tbl[5] = '{1'b0, 4'd2,  8'h00, 8'h34};

    repeat (3) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].we) host_write(tbl[i].addr, tbl[i].wdata);
      host_read(tbl[i].addr, d);
      check($sformatf("host_vec%0d", i), d, tbl[i].exp);
    end

    // Write burst with pointer increment
    i2c_start();
    write_byte(8'h50, -1, ack); check("burst_addr_ack", ack, 0);
    write_byte(8'h03, -1, ack); check("burst_reg_ack", ack, 0);
    exp_wr.push_back({4'd3, 8'hA5});
    write_byte(8'hA5, -1, ack); check("burst_d0_ack", ack, 0);
    exp_wr.push_back({4'd4, 8'h5A});
    write_byte(8'h5A, -1, ack); check("burst_d1_ack", ack, 0);
    check("burst_busy", busy, 1);
    i2c_stop();
    check("burst_busy_after_stop", busy, 0);
    host_read(4'd3, d); check("burst_reg3", d, 8'hA5);
    host_read(4'd4, d); check("burst_reg4", d, 8'h5A);

    // Random read with repeated START
    host_write(4'd7, 8'h3C);
    host_write(4'd8, 8'hC3);
    i2c_start();
    write_byte(8'h50, -1, ack); check("rd_addr_ack", ack, 0);
    write_byte(8'h07, -1, ack); check("rd_reg_ack", ack, 0);
    i2c_start();
    write_byte(8'h51, -1, ack); check("rd_sr_addr_ack", ack, 0);
    exp_rd.push_back(8'h3C); read_check("rd_byte0", 1'b0);
    exp_rd.push_back(8'hC3); read_check("rd_byte1", 1'b1);
    wait_q();
    check("rd_sda_released_after_nack", sda_oe, 0);
    check("rd_busy_before_stop", busy, 1);
    i2c_stop();
    check("rd_busy_after_stop", busy, 0);

    // Pointer wrap at NUM_REGS-1
    i2c_start();
    write_byte(8'h50, -1, ack);
    write_byte(8'h0F, -1, ack);
    exp_wr.push_back({4'd15, 8'h01}); write_byte(8'h01, -1, ack);
    exp_wr.push_back({4'd0, 8'h02});  write_byte(8'h02, -1, ack);
    exp_wr.push_back({4'd1, 8'h03});  write_byte(8'h03, -1, ack);
    check("wrap_last_ack", ack, 0);
    i2c_stop();
    host_read(4'd15, d); check("wrap_reg15", d, 8'h01);
    host_read(4'd0, d);  check("wrap_reg0", d, 8'h02);
    host_read(4'd1, d);  check("wrap_reg1", d, 8'h03);

    // Address mismatch: slave must stay silent
    oe_cnt = 0; busy_cnt = 0; wv_cnt = 0;
    i2c_start();
    write_byte(8'h52, -1, ack); check("mismatch_nack", ack, 1);
    write_byte(8'hA5, -1, ack); check("mismatch_data_nack", ack, 1);
    i2c_stop();
    check("mismatch_oe_cycles", oe_cnt, 0);
    check("mismatch_busy_cycles", busy_cnt, 0);
    check("mismatch_wr_valid", wv_cnt, 0);

    // 1-clk SCL glitch during a data bit must not shift a bit
    i2c_start();
    write_byte(8'h50, -1, ack);
    write_byte(8'h05, -1, ack);
    exp_wr.push_back({4'd5, 8'h96});
    write_byte(8'h96, 3, ack); check("glitch_ack", ack, 0);
    i2c_stop();
    host_read(4'd5, d); check("glitch_reg5", d, 8'h96);

    // Host and bus write reg3 in the same cycle: bus wins
    i2c_start();
    write_byte(8'h50, -1, ack);
    write_byte(8'h03, -1, ack);
    exp_wr.push_back({4'd3, 8'h11});
    host_addr = 4'd3; host_wdata = 8'h77; host_we = 1'b1;
    got = 1'b0;
    fork
      write_byte(8'h11, -1, ack);
      begin
        for (int i = 0; i < 600 && !wr_valid; i++) @(negedge clk);
        got = wr_valid;
        host_we = 1'b0;
      end
    join
    check("collision_wr_seen", got, 1);
    i2c_stop();
    host_read(4'd3, d); check("collision_reg3", d, 8'h11);

    // Reset during a read byte
    i2c_start();
    write_byte(8'h50, -1, ack);
    write_byte(8'h09, -1, ack);
    i2c_start();
    write_byte(8'h51, -1, ack); check("rst_rd_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, 1'b0, got);
    wait_q();
    check("rst_rd_oe_driving", sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check("rst_rd_oe_async", sda_oe, 0);
    check("rst_rd_busy_async", busy, 0);
    @(negedge clk);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_rd_idle_busy", busy, 0);
    i2c_start();
    write_byte(8'h51, -1, ack); check("post_rst_addr_ack", ack, 0);
    exp_rd.push_back(8'h00); read_check("post_rst_byte", 1'b1);
    i2c_stop();
    host_read(4'd7, d); check("post_rst_reg7", d, 8'h00);

    repeat (10) @(negedge clk);
    check("wr_scoreboard_drained", exp_wr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
